sisc_ctrl: RTL and testbench

Multi-cycle control unit for the SISC processor. It sequences the PC, instruction register, register file, ALU, status register and data memory through fixed FETCH/DECODE/EXECUTE/MEM/WRITEBACK phases. It sits inside sisc, fed by the IR opcode/mask fields and the status register, and drives every datapath enable and mux select.

---
 rtl/sisc_pkg.sv | 27 ++
 rtl/sisc_br_eval.sv | 38 +++
 rtl/sisc_ctrl.sv | 125 ++++++++++++
 tb/tb_sisc_ctrl.sv | 119 +++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// Shared constants for the SISC control path: opcodes, FSM state codes and ALU op selects.
package sisc_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ALU = 4'b0001;
  localparam logic [3:0] OP_LOD = 4'b0010;
  localparam logic [3:0] OP_STR = 4'b0011;
  localparam logic [3:0] OP_BRA = 4'b0100;
  localparam logic [3:0] OP_BRR = 4'b0101;
  localparam logic [3:0] OP_BNE = 4'b0110;
  localparam logic [3:0] OP_BNR = 4'b0111;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [2:0] S_START0    = 3'b000;
  localparam logic [2:0] S_START1    = 3'b001;
  localparam logic [2:0] S_FETCH     = 3'b010;
  localparam logic [2:0] S_DECODE    = 3'b011;
  localparam logic [2:0] S_EXECUTE   = 3'b100;
  localparam logic [2:0] S_MEM       = 3'b101;
  localparam logic [2:0] S_WRITEBACK = 3'b110;
  localparam logic [2:0] S_HALT      = 3'b111;

  localparam logic [1:0] ALU_FN   = 2'b00;
  localparam logic [1:0] ALU_ADDR = 2'b01;
  localparam logic [1:0] ALU_PASS = 2'b10;

endpackage

// File: rtl/sisc_br_eval.sv
// Branch condition evaluator: decides whether a conditional branch is taken and
// whether its target is absolute or PC-relative.
module sisc_br_eval
  import sisc_pkg::*;
#(
  parameter int OPW = 4,
  parameter int MMW = 4
) (
  input  logic [OPW-1:0] opcode,
  input  logic [MMW-1:0] mm,
  input  logic [MMW-1:0] stat,
  output logic           taken,
  output logic           br_sel
);

  // An empty mask never matches, so BRA/BRR fall through and BNE/BNR always go.
  logic hit;
  assign hit = |(stat & mm);

  always_comb begin
    taken  = 1'b0;
    br_sel = 1'b0;
    case (opcode)
      OP_BRA: taken = hit;
      OP_BRR: begin
        taken  = hit;
        br_sel = 1'b1;
      end
      OP_BNE: taken = ~hit;
      OP_BNR: begin
        taken  = ~hit;
        br_sel = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sisc_ctrl.sv
// Multi-cycle SISC control unit: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer
// driving all datapath enables and mux selects.
module sisc_ctrl
  import sisc_pkg::*;
#(
  parameter int OPW = 4,
  parameter int MMW = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [OPW-1:0] opcode,
  input  logic [MMW-1:0] mm,
  input  logic [MMW-1:0] stat,
  output logic           pc_rst,
  output logic           pc_write,
  output logic           pc_sel,
  output logic           br_sel,
  output logic           ir_load,
  output logic           rd_sel,
  output logic [1:0]     alu_op,
  output logic           rf_we,
  output logic           wb_sel,
  output logic           dm_we,
  output logic           stat_en,
  output logic           halted,
  output logic [2:0]     state_o
);

  logic [2:0] state_reg;
  logic [2:0] state_next;
  logic       br_taken;
  logic       br_rel;

  sisc_br_eval #(.OPW(OPW), .MMW(MMW)) u_br_eval (
    .opcode (opcode),
    .mm     (mm),
    .stat   (stat),
    .taken  (br_taken),
    .br_sel (br_rel)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_START0:    state_next = S_START1;
      S_START1:    state_next = S_FETCH;
      S_FETCH:     state_next = S_DECODE;
      S_DECODE:    state_next = (opcode == OP_HLT) ? S_HALT : S_EXECUTE;
      S_EXECUTE:   state_next = S_MEM;
      S_MEM:       state_next = S_WRITEBACK;
      S_WRITEBACK: state_next = S_FETCH;
      S_HALT:      state_next = S_HALT;
      default:     state_next = S_START0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state_reg <= S_START0;
    else     state_reg <= state_next;
  end

  assign state_o = state_reg;

  always_comb begin
    pc_rst   = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    ir_load  = 1'b0;
    rd_sel   = 1'b0;
    alu_op   = ALU_FN;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    dm_we    = 1'b0;
    stat_en  = 1'b0;
    halted   = 1'b0;

    // The ALU op is held over the whole EXECUTE..WRITEBACK span so the datapath result stays stable.
    if (state_reg == S_EXECUTE || state_reg == S_MEM || state_reg == S_WRITEBACK) begin
      if (opcode == OP_LOD || opcode == OP_STR) alu_op = ALU_ADDR;
    end

    case (state_reg)
      S_START0: pc_rst = 1'b1;
      S_FETCH: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
      end
      S_DECODE: begin
        if (br_taken) begin
          pc_write = 1'b1;
          pc_sel   = 1'b1;
          br_sel   = br_rel;
        end
      end
      S_EXECUTE: rd_sel = (opcode == OP_STR);
      S_MEM: begin
        rd_sel = (opcode == OP_STR);
        dm_we  = (opcode == OP_STR);
      end
      S_WRITEBACK: begin
        if (opcode == OP_ALU) begin
          rf_we   = 1'b1;
          stat_en = 1'b1;
        end else if (opcode == OP_LOD) begin
          rf_we  = 1'b1;
          wb_sel = 1'b1;
        end
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase

    // Reset overrides any in-flight instruction before the state register catches up.
    if (RST) begin
      pc_rst   = 1'b1;
      pc_write = 1'b0;
      ir_load  = 1'b0;
      rf_we    = 1'b0;
      dm_we    = 1'b0;
      stat_en  = 1'b0;
    end
  end

endmodule

// File: tb/tb_sisc_ctrl.sv
// Directed bench for sisc_ctrl: walks reset, each instruction class, branches, halt
// and a mid-instruction reset, checking the full output vector every cycle.
module tb_sisc_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] opcode;
  logic [3:0] mm;
  logic [3:0] stat;
  logic       pc_rst, pc_write, pc_sel, br_sel, ir_load, rd_sel;
  logic [1:0] alu_op;
  logic       rf_we, wb_sel, dm_we, stat_en, halted;
  logic [2:0] state_o;

  int total_cnt = 0;
  int pass_cnt  = 0;

  // Output vector bit positions; the low 3 bits carry state_o.
  localparam logic [15:0] PCR = 16'h8000;
  localparam logic [15:0] PCW = 16'h4000;
  localparam logic [15:0] PCS = 16'h2000;
  localparam logic [15:0] BRS = 16'h1000;
  localparam logic [15:0] IRL = 16'h0800;
  localparam logic [15:0] RDS = 16'h0400;
  localparam logic [15:0] AAD = 16'h0100;
  localparam logic [15:0] RFW = 16'h0080;
  localparam logic [15:0] WBS = 16'h0040;
  localparam logic [15:0] DMW = 16'h0020;
  localparam logic [15:0] STE = 16'h0010;
  localparam logic [15:0] HLT = 16'h0008;

  logic [15:0] obs;
  assign obs = {pc_rst, pc_write, pc_sel, br_sel, ir_load, rd_sel, alu_op,
                rf_we, wb_sel, dm_we, stat_en, halted, state_o};

  sisc_ctrl dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .mm(mm), .stat(stat),
    .pc_rst(pc_rst), .pc_write(pc_write), .pc_sel(pc_sel), .br_sel(br_sel),
    .ir_load(ir_load), .rd_sel(rd_sel), .alu_op(alu_op), .rf_we(rf_we),
    .wb_sel(wb_sel), .dm_we(dm_we), .stat_en(stat_en), .halted(halted),
    .state_o(state_o)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step(input string tag, input logic [15:0] exp);
    @(posedge CLK);
    #2;
    chk(tag, exp);
  endtask

  // Runs one instruction from FETCH: checks DECODE, EXECUTE, MEM, WRITEBACK and the next FETCH.
  task automatic instr(input string tag, input logic [3:0] op, input logic [3:0] m,
                       input logic [3:0] s, input logic [15:0] dec_e,
                       input logic [15:0] ex_e, input logic [15:0] mem_e,
                       input logic [15:0] wb_e);
    opcode = op;
    mm     = m;
    stat   = s;
    step({tag, "_decode"}, dec_e | 16'd3);
    step({tag, "_execute"}, ex_e | 16'd4);
    step({tag, "_mem"}, mem_e | 16'd5);
    step({tag, "_writeback"}, wb_e | 16'd6);
    step({tag, "_fetch"}, PCW | IRL | 16'd2);
  endtask

  initial begin
    RST = 1'b1; opcode = 4'h0; mm = 4'h0; stat = 4'h0;

    step("rst_start0_a", PCR | 16'd0);
    step("rst_start0_b", PCR | 16'd0);
    RST = 1'b0;
    #1 chk("rst_release", PCR | 16'd0);
    step("start1", 16'd1);
    step("fetch", PCW | IRL | 16'd2);

    instr("alu", 4'b0001, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, RFW | STE);
    instr("lod", 4'b0010, 4'h0, 4'h0, 16'h0, AAD, AAD, AAD | RFW | WBS);
    instr("str", 4'b0011, 4'h0, 4'h0, 16'h0, AAD | RDS, AAD | RDS | DMW, AAD);
    instr("bra_taken", 4'b0100, 4'b0100, 4'b0100, PCW | PCS, 16'h0, 16'h0, 16'h0);
    instr("bra_not", 4'b0100, 4'b0100, 4'b0010, 16'h0, 16'h0, 16'h0, 16'h0);
    instr("bnr_taken", 4'b0111, 4'b0001, 4'b0000, PCW | PCS | BRS, 16'h0, 16'h0, 16'h0);
    instr("brr_mm0", 4'b0101, 4'b0000, 4'b1111, 16'h0, 16'h0, 16'h0, 16'h0);
    instr("bne_mm0", 4'b0110, 4'b0000, 4'b1111, PCW | PCS, 16'h0, 16'h0, 16'h0);
    instr("brr_taken", 4'b0101, 4'b1000, 4'b1001, PCW | PCS | BRS, 16'h0, 16'h0, 16'h0);
    instr("undef_nop", 4'b1010, 4'b1111, 4'b1111, 16'h0, 16'h0, 16'h0, 16'h0);

    opcode = 4'b1111;
    step("hlt_decode", 16'd3);
    for (int i = 0; i < 20; i++) step("halt_hold", HLT | 16'd7);
    RST = 1'b1;
    #1 chk("halt_rst_comb", PCR | HLT | 16'd7);
    step("halt_rst_start0", PCR | 16'd0);
    RST = 1'b0;
    step("re_start1", 16'd1);
    step("re_fetch", PCW | IRL | 16'd2);

    opcode = 4'b0001;
    step("mid_decode", 16'd3);
    step("mid_execute", 16'd4);
    step("mid_mem", 16'd5);
    step("mid_writeback", RFW | STE | 16'd6);
    RST = 1'b1;
    #1 chk("mid_rst_comb", PCR | 16'd6);
    step("mid_rst_start0", PCR | 16'd0);
    RST = 1'b0;
    step("mid_start1", 16'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
